// File: rtl/odd_even_sort_engine.sv
// Batch sorter: loads NUM_ELEM words, runs NUM_ELEM odd-even transposition phases,
// then streams the words out in ascending order with a valid/ready handshake.
module odd_even_sort_engine #(
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned NUM_ELEM  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic                 o_busy
);

    localparam int unsigned IdxW = $clog2(NUM_ELEM);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ELEM - 1);

    typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q;
    logic [IdxW-1:0]      phase_q;
    logic [SIZE_DATA-1:0] arr_q   [NUM_ELEM];
    logic [SIZE_DATA-1:0] arr_swp [NUM_ELEM];
    logic                 accept;
    logic                 drain_hs;

    // Pairs are disjoint within a phase, so every swap reads the registered array.
    always_comb begin
        arr_swp = arr_q;
        for (int i = 0; i < NUM_ELEM - 1; i++) begin
            if (1'(i % 2) == phase_q[0]) begin
                if (arr_q[i] > arr_q[i+1]) begin
                    arr_swp[i]   = arr_q[i+1];
                    arr_swp[i+1] = arr_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        drain_hs = 1'b0;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        o_last   = 1'b0;
        o_busy   = 1'b0;
        unique case (state_q)
            StLoad: begin
                o_ready = !i_rst;
                accept  = i_valid;
                if (i_valid && idx_q == LastIdx) state_d = StSort;
            end
            StSort: begin
                o_busy = 1'b1;
                if (phase_q == LastIdx) state_d = StDrain;
            end
            StDrain: begin
                o_busy   = 1'b1;
                o_valid  = 1'b1;
                o_last   = (idx_q == LastIdx);
                drain_hs = i_ready;
                if (i_ready && idx_q == LastIdx) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    assign o_data = arr_q[idx_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= StLoad;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q   <= '0;
            phase_q <= '0;
            arr_q   <= '{default: '0};
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        arr_q[idx_q] <= i_data;
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            phase_q <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StSort: begin
                    arr_q   <= arr_swp;
                    phase_q <= (phase_q == LastIdx) ? '0 : phase_q + 1'b1;
                end
                StDrain: begin
                    if (drain_hs) idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_odd_even_sort_engine.sv
// Scoreboard bench: driver pushes the sorted batch into a queue, monitor pops on handshakes.
module tb_odd_even_sort_engine;

    localparam int N = 8;
    localparam int W = 8;

    typedef logic [W-1:0] batch_t [N];
    typedef struct { logic [W-1:0] data; logic last; } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready_dn = 1'b1;
    logic         eng_ready, eng_valid, eng_last, eng_busy;
    logic [W-1:0] eng_data;

    odd_even_sort_engine #(.SIZE_DATA(W), .NUM_ELEM(N)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(in_valid),
        .i_data (in_data),
        .o_ready(eng_ready),
        .o_valid(eng_valid),
        .o_data (eng_data),
        .o_last (eng_last),
        .i_ready(out_ready_dn),
        .o_busy (eng_busy)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    int   last_accept_cyc = 0;
    int   ready_mode = 0;
    bit   lat_en = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: ordered insertion into a queue, then tag the final element.
    task automatic push_expected(input batch_t b);
        logic [W-1:0] s[$];
        int pos;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            pos = 0;
            while (pos < s.size() && s[pos] <= b[i]) pos++;
            s.insert(pos, b[i]);
        end
        for (int i = 0; i < N; i++) begin
            e.data = s[i];
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic put_word(input logic [W-1:0] v, input bit gap);
        int waited = 0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            if (eng_ready) break;
            if (++waited > 200) begin
                check("ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        last_accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input batch_t b, input bit gaps, input bit no_expect);
        for (int i = 0; i < N; i++) put_word(b[i], gaps && (i % 2 == 1));
        if (!no_expect) push_expected(b);
    endtask

    task automatic wait_empty();
        int waited = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            if (++waited > 300) begin
                check("drain_timeout", exp_q.size(), 0);
                exp_q.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic batch_t rand_batch();
        batch_t b;
        for (int i = 0; i < N; i++) b[i] = W'($urandom);
        return b;
    endfunction

    // Downstream ready: 0 always high, 1 pattern 1,0,0, 2 random.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready_dn = 1'b1;
                1:       out_ready_dn = (k % 3 == 0);
                default: out_ready_dn = 1'($urandom);
            endcase
            k++;
        end
    end

    // Monitor: a handshake happens at the posedge following a negedge with valid&&ready.
    initial begin
        bit           prev_valid = 1'b0;
        bit           hold_valid = 1'b0;
        logic [W-1:0] hold_data = '0;
        logic         hold_last = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                hold_valid = 1'b0;
            end else if (eng_valid) begin
                check("ready_in_drain", int'(eng_ready), 0);
                // Cycles counted with the one following the accepting edge as cycle 1.
                if (!prev_valid && lat_en)
                    check("first_valid_latency", cyc - last_accept_cyc + 1, N + 1);
                if (hold_valid) begin
                    check("stall_data", int'(eng_data), int'(hold_data));
                    check("stall_last", int'(eng_last), int'(hold_last));
                end
                if (out_ready_dn) begin
                    hold_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", int'(eng_data), int'(e.data));
                        check("last", int'(eng_last), int'(e.last));
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = eng_data;
                    hold_last  = eng_last;
                end
                prev_valid = 1'b1;
            end else begin
                if (eng_last) check("last_outside_drain", int'(eng_last), 0);
                prev_valid = 1'b0;
                hold_valid = 1'b0;
            end
        end
    end

    initial begin
        batch_t b;
        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(eng_ready), 0);
        check("rst_valid", int'(eng_valid), 0);
        check("rst_busy", int'(eng_busy), 0);
        check("rst_last", int'(eng_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(eng_ready), 1);
        check("post_rst_busy", int'(eng_busy), 0);
        @(posedge clk); #1;

        // Reversed input, ready held high, latency checked
        ready_mode = 0; lat_en = 1'b1;
        b = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        send_batch(b, 1'b0, 1'b0);
        wait_empty();

        // Unsigned extremes and duplicates
        b = '{8'd255, 8'd0, 8'd128, 8'd0, 8'd255, 8'd1, 8'd1, 8'd127};
        send_batch(b, 1'b0, 1'b0);
        wait_empty();

        // Pre-sorted input with i_valid gaps
        lat_en = 1'b0;
        b = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        send_batch(b, 1'b1, 1'b0);
        wait_empty();

        // Downstream stalls with pattern 1,0,0
        ready_mode = 1;
        send_batch(rand_batch(), 1'b0, 1'b0);
        wait_empty();

        // Reset while phase 3 is sorting
        ready_mode = 0;
        send_batch(rand_batch(), 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", int'(eng_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_busy", int'(eng_busy), 0);
        check("after_rst_valid", int'(eng_valid), 0);
        check("after_rst_ready", int'(eng_ready), 1);
        check("after_rst_last", int'(eng_last), 0);
        @(posedge clk); #1;
        lat_en = 1'b1;
        b = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
        send_batch(b, 1'b0, 1'b0);
        wait_empty();

        // Back-to-back random batches with random downstream ready
        lat_en = 1'b0;
        ready_mode = 2;
        for (int n = 0; n < 6; n++) send_batch(rand_batch(), 1'b0, 1'b0);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/odd_even_sort_engine.md
ODD_EVEN_SORT_ENGINE -- requirements
Module: odd_even_sort_engine

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, word width in bits.
REQ-002 SHALL have parameter NUM_ELEM, default 8, words per batch; even, >= 2.
REQ-003 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  input word valid.
REQ-006 SHALL have port i_data  input  SIZE_DATA  input word, unsigned.
REQ-007 SHALL have port o_ready  output  1  engine accepts input word this cycle.
REQ-008 SHALL have port o_valid  output  1  sorted output word valid.
REQ-009 SHALL have port o_data  output  SIZE_DATA  sorted output word.
REQ-010 SHALL have port o_last  output  1  o_data is final word of the batch.
REQ-011 SHALL have port i_ready  input  1  downstream accepts output word.
REQ-012 SHALL have port o_busy  output  1  high in SORT or DRAIN state.

Function
REQ-013 SHALL implement a three-state FSM: LOAD, SORT, DRAIN; no other states.
REQ-014 SHALL hold a register array of NUM_ELEM words, a load/drain index counter (0..NUM_ELEM-1) and a phase counter (0..NUM_ELEM-1).
REQ-015 LOAD: o_ready=1, o_valid=0; on i_valid&&o_ready, SHALL write i_data to array[index] and increment index; i_valid low cycles insert no data.
REQ-016 LOAD: on acceptance with index==NUM_ELEM-1, SHALL clear index, clear phase, enter SORT next cycle.
REQ-017 SORT: o_ready=0, o_valid=0; one transposition phase per cycle.
REQ-018 Even phase (phase[0]==0) SHALL compare-swap pairs (0,1),(2,3),...,(NUM_ELEM-2,NUM_ELEM-1); odd phase SHALL compare-swap (1,2),(3,4),...,(NUM_ELEM-3,NUM_ELEM-2); index 0 and NUM_ELEM-1 untouched in odd phases.
REQ-019 Compare-swap SHALL be unsigned, full SIZE_DATA width: lower index receives the lesser word, higher index the greater; on equality, words unchanged.
REQ-020 After phase NUM_ELEM-1 executes, SHALL enter DRAIN next cycle; sort takes exactly NUM_ELEM cycles regardless of data.
REQ-021 DRAIN: o_valid=1, o_data=array[index], o_last=1 iff index==NUM_ELEM-1, o_ready=0.
REQ-022 DRAIN: on o_valid&&i_ready, SHALL increment index; o_data/o_last SHALL stay stable while i_ready=0.
REQ-023 DRAIN: on handshake with index==NUM_ELEM-1, SHALL clear index and enter LOAD next cycle; no overlap of drain and next load.
REQ-024 Latency: with i_ready held high, first o_valid SHALL appear NUM_ELEM+1 cycles after the edge accepting the final input word; words then exit one per cycle, ascending.
REQ-025 o_last SHALL be 0 outside DRAIN; o_busy SHALL be 0 in LOAD.
REQ-026 Outputs SHALL be driven from registered state only (no combinational path i_data -> o_data).

Reset
REQ-027 While i_rst=1 at a rising edge, SHALL set FSM=LOAD, index=0, phase=0, array words=0.
REQ-028 During and after reset cycle: o_valid=0, o_last=0, o_busy=0; o_ready=0 while i_rst=1, 1 from first cycle with i_rst=0.
REQ-029 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the batch; no partial output after deassertion.

Verification
REQ-030 Load 7,6,5,4,3,2,1,0 (NUM_ELEM=8, i_ready=1) -> o_data 0..7 on 8 consecutive cycles, o_last with 7, first o_valid 9 cycles after last accept.
REQ-031 Load 255,0,128,0,255,1,1,127 -> 0,0,1,1,127,128,255,255 (unsigned, duplicates preserved).
REQ-032 Load already-sorted 10..17 with i_valid gaps every other cycle -> same 10..17 out; index advances only on handshake.
REQ-033 Drain with i_ready toggling 1,0,0,1,... -> o_data/o_last stable during stalls, each word emitted once, o_ready=0 until after final handshake.
REQ-034 Assert i_rst during SORT phase 3 -> next cycle o_busy=0, o_valid=0, o_ready=1 after deassertion; new batch 3,1 ... sorts correctly, no stale words.
REQ-035 Back-to-back batches: second batch loads only after first o_last handshake; both batches emerge fully sorted.
